// File: rtl/acondicionador_botones.sv
// -----------------------------------------------------------------------------
// acondicionador_botones
//
// Purpose
//   Conditions the raw board buttons and the program switch before they reach
//   the RTC controller. Every input runs through its own channel:
//     2-flop synchroniser -> debounce counter -> stable level.
//   Buttons turn each 0->1 change of the stable level into a one-clock pulse.
//   The switch is passed through as a level.
//
//   U/D and R/L are mutually exclusive. If both buttons of a pair would pulse
//   in the same cycle, neither pulse is emitted. Their stable levels still
//   update, so later presses behave normally.
//
// Optional feature (macro AUTOREPEAT_EN)
//   When defined, holding BTNU or BTND auto-repeats its pulse.
//   The first repeat comes REP_DELAY cycles after the initial pulse.
//   Further repeats come every REP_PERIOD cycles while the button stays held.
//   Without the macro no timer logic is built and every press gives one pulse.
//
// Ports
//   clock        in   system clock
//   reset        in   asynchronous, active-high reset
//   BTNP_raw     in   raw program/mode button
//   BTNU_raw     in   raw up button
//   BTND_raw     in   raw down button
//   BTNR_raw     in   raw right button
//   BTNL_raw     in   raw left button
//   switchp_raw  in   raw program switch
//   BTNP         out  one-cycle press pulse
//   BTNU         out  one-cycle press pulse (auto-repeats with AUTOREPEAT_EN)
//   BTND         out  one-cycle press pulse (auto-repeats with AUTOREPEAT_EN)
//   BTNR         out  one-cycle press pulse
//   BTNL         out  one-cycle press pulse
//   switchp      out  debounced level of switchp_raw
// -----------------------------------------------------------------------------
module acondicionador_botones #(
  parameter int DEB_CYCLES = 1000000,
  parameter int REP_DELAY  = 50000000,
  parameter int REP_PERIOD = 20000000
) (
  input  logic clock,
  input  logic reset,
  input  logic BTNP_raw,
  input  logic BTNU_raw,
  input  logic BTND_raw,
  input  logic BTNR_raw,
  input  logic BTNL_raw,
  input  logic switchp_raw,
  output logic BTNP,
  output logic BTNU,
  output logic BTND,
  output logic BTNR,
  output logic BTNL,
  output logic switchp
);

  // Channel order: 0=P, 1=U, 2=D, 3=R, 4=L, 5=switch.
  localparam int NCH = 6;
  localparam int CW  = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] DEB_ONE  = CW'(1);

  logic [NCH-1:0] raw_in;
  logic [NCH-1:0] sync1_q;
  logic [NCH-1:0] sync2_q;
  logic [NCH-1:0] stable_q;
  logic [NCH-1:0] stable_d;
  logic [CW-1:0]  deb_cnt_q [NCH];
  logic [CW-1:0]  deb_cnt_d [NCH];

  // Button-only pulse path (bits 0..4).
  logic [4:0] prev_q;
  logic [4:0] rise;
  logic [4:0] pulse_src;
  logic [4:0] pulse_d;
  logic [4:0] pulse_q;
  logic       switch_q;

  // Repeat requests: bit 0 = U, bit 1 = D.
  logic [1:0] rep_fire;

  assign raw_in = {switchp_raw, BTNL_raw, BTNR_raw, BTND_raw, BTNU_raw, BTNP_raw};

  // Debounce: the counter runs only while the synchronised level disagrees
  // with the accepted level. Any agreement clears it, so only a run of
  // DEB_CYCLES disagreeing samples is accepted.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        stable_d[i]  = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DEB_ONE;
      end
    end
  end

  // A rise is the stable level being high now but low one cycle earlier.
  assign rise      = stable_q[4:0] & ~prev_q;
  assign pulse_src = rise | {2'b00, rep_fire, 1'b0};

  // Pair exclusion. This also covers repeat pulses, since they are part of
  // pulse_src.
  always_comb begin
    pulse_d    = pulse_src;
    pulse_d[1] = pulse_src[1] & ~pulse_src[2];
    pulse_d[2] = pulse_src[2] & ~pulse_src[1];
    pulse_d[3] = pulse_src[3] & ~pulse_src[4];
    pulse_d[4] = pulse_src[4] & ~pulse_src[3];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      pulse_q  <= '0;
      switch_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= raw_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q[4:0];
      pulse_q  <= pulse_d;
      // Registered like the pulses, so all outputs share one pipeline depth.
      switch_q <= stable_q[5];
      for (int i = 0; i < NCH; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] REP_DELAY_LAST  = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] REP_PERIOD_LAST = RW'(REP_PERIOD - 1);
  localparam logic [RW-1:0] REP_ONE         = RW'(1);

  // "held" excludes the rise cycle itself, so the timer starts counting on
  // the edge that registers the initial pulse.
  logic [1:0]    rep_held;
  logic [1:0]    rep_periodic_q;   // 0: waiting REP_DELAY, 1: repeating every REP_PERIOD
  logic [1:0]    rep_periodic_d;
  logic [RW-1:0] rep_cnt_q [2];
  logic [RW-1:0] rep_cnt_d [2];

  assign rep_held = stable_q[2:1] & prev_q[2:1];

  always_comb begin
    rep_fire       = 2'b00;
    rep_periodic_d = rep_periodic_q;
    for (int j = 0; j < 2; j++) begin
      rep_cnt_d[j] = rep_cnt_q[j];
      if (!rep_held[j]) begin
        rep_cnt_d[j]      = '0;
        rep_periodic_d[j] = 1'b0;
      end else if (rep_cnt_q[j] == (rep_periodic_q[j] ? REP_PERIOD_LAST : REP_DELAY_LAST)) begin
        rep_fire[j]       = 1'b1;
        rep_cnt_d[j]      = '0;
        rep_periodic_d[j] = 1'b1;
      end else begin
        rep_cnt_d[j] = rep_cnt_q[j] + REP_ONE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_periodic_q <= 2'b00;
      rep_cnt_q[0]   <= '0;
      rep_cnt_q[1]   <= '0;
    end else begin
      rep_periodic_q <= rep_periodic_d;
      rep_cnt_q[0]   <= rep_cnt_d[0];
      rep_cnt_q[1]   <= rep_cnt_d[1];
    end
  end
`else
  assign rep_fire = 2'b00;
`endif

  assign BTNP    = pulse_q[0];
  assign BTNU    = pulse_q[1];
  assign BTND    = pulse_q[2];
  assign BTNR    = pulse_q[3];
  assign BTNL    = pulse_q[4];
  assign switchp = switch_q;

endmodule

// File: tb/tb_acondicionador_botones.sv
// -----------------------------------------------------------------------------
// tb_acondicionador_botones
//
// Drives the conditioner with DEB_CYCLES=4, REP_DELAY=20 and REP_PERIOD=8 on a
// 10 ns clock. A behavioural model predicts the outputs for every cycle:
//   - A level is accepted after DEB_CYCLES consecutive disagreeing samples.
//   - A press pulse follows each accepted rise.
//   - Repeats fall on press + REP_DELAY + k*REP_PERIOD.
//   - The exclusion rule is applied on top.
// Directed scenarios also check specific cycle numbers and pulse counts.
// -----------------------------------------------------------------------------
module tb_acondicionador_botones;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
`ifdef AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  // clock / reset
  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] raw = '0;   // 0=P 1=U 2=D 3=R 4=L 5=switch
  logic       BTNP, BTNU, BTND, BTNR, BTNL, switchp;

  always #5 clock = ~clock;

  acondicionador_botones #(
    .DEB_CYCLES (DEB),
    .REP_DELAY  (RD),
    .REP_PERIOD (RP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .BTNP_raw    (raw[0]),
    .BTNU_raw    (raw[1]),
    .BTND_raw    (raw[2]),
    .BTNR_raw    (raw[3]),
    .BTNL_raw    (raw[4]),
    .switchp_raw (raw[5]),
    .BTNP        (BTNP),
    .BTNU        (BTNU),
    .BTND        (BTND),
    .BTNR        (BTNR),
    .BTNL        (BTNL),
    .switchp     (switchp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: expected {P,U,D,R,L,switch} after each clock edge.
  logic [5:0] exp_q[$];

  // Reference model state
  logic [5:0] m_hist[$];     // sampled raw values, newest first
  logic [5:0] m_stab;        // accepted levels after the previous edge
  logic [5:0] m_stab_prev;   // accepted levels one edge earlier
  int         m_edge;
  int         m_press[2];    // edge of last U / D press

  task automatic model_reset();
    m_hist.delete();
    exp_q.delete();
    m_stab      = '0;
    m_stab_prev = '0;
    m_edge      = 0;
    m_press[0]  = 0;
    m_press[1]  = 0;
  endtask

  task automatic model_edge(input logic [5:0] samp);
    logic [5:0] nxt;
    logic [4:0] rise, held, src, pul;
    logic       v;
    bit         all_diff;
    int         d;
    m_edge++;
    m_hist.push_front(samp);
    while (m_hist.size() > DEB + 2) void'(m_hist.pop_back());
    // The synchroniser delays each sample by two edges. A level flips once
    // DEB consecutive delayed samples all disagree with it.
    nxt = m_stab;
    for (int ch = 0; ch < 6; ch++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        v = (2 + j < m_hist.size()) ? m_hist[2 + j][ch] : 1'b0;
        if (v == m_stab[ch]) all_diff = 1'b0;
      end
      if (all_diff) nxt[ch] = ~m_stab[ch];
    end
    rise = m_stab[4:0] & ~m_stab_prev[4:0];
    held = m_stab[4:0] & m_stab_prev[4:0];
    src  = rise;
    for (int k = 0; k < 2; k++) begin
      if (rise[k + 1]) begin
        m_press[k] = m_edge;
      end else if (AR && held[k + 1]) begin
        d = m_edge - m_press[k];
        if (d >= RD && (d - RD) % RP == 0) src[k + 1] = 1'b1;
      end
    end
    pul    = src;
    pul[1] = src[1] & ~src[2];
    pul[2] = src[2] & ~src[1];
    pul[3] = src[3] & ~src[4];
    pul[4] = src[4] & ~src[3];
    exp_q.push_back({pul[0], pul[1], pul[2], pul[3], pul[4], m_stab[5]});
    m_stab_prev = m_stab;
    m_stab      = nxt;
  endtask

  // Driver: one clock edge with the current raw value; sample 1 ns later.
  task automatic step();
    logic [5:0] samp;
    samp = raw;
    @(posedge clock);
    #1;
    model_edge(samp);
  endtask

  task automatic test_reset();
    logic [5:0] e, o;
    reset = 1'b1;
    raw   = '0;
    #3;
    o = {BTNP, BTNU, BTND, BTNR, BTNL, switchp};
    n_cmp++;
    if (o !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 000000", o);
    end
    #7;
    reset = 1'b0;
    model_reset();
    for (int c = 1; c <= 4; c++) begin
      step();
      e = exp_q.pop_front();
      o = {BTNP, BTNU, BTND, BTNR, BTNL, switchp};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL reset_idle c%0d: got %b expected %b", c, o, e);
      end
    end
  endtask

  task automatic test_single_press();
    logic [5:0] e, o;
    int first = 0;
    int cnt   = 0;
    for (int c = 1; c <= 35; c++) begin
      raw[1] = (c <= 20);
      step();
      e = exp_q.pop_front();
      o = {BTNP, BTNU, BTND, BTNR, BTNL, switchp};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL single_press c%0d: got %b expected %b", c, o, e);
      end
      if (BTNU === 1'b1) begin
        cnt++;
        if (first == 0) first = c;
      end
    end
    n_cmp++;
    if (first != DEB + 3) begin
      n_bad++;
      $display("FAIL single_press_latency: got step %0d expected %0d", first, DEB + 3);
    end
    n_cmp++;
    if (cnt != 1) begin
      n_bad++;
      $display("FAIL single_press_count: got %0d expected 1", cnt);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] e, o;
    int first = 0;
    int cnt   = 0;
    for (int c = 1; c <= 45; c++) begin
      // Low/high in pairs for 10 cycles, then steady high from step 11.
      if (c <= 10)      raw[3] = (((c - 1) / 2) % 2 == 1);
      else if (c <= 30) raw[3] = 1'b1;
      else              raw[3] = 1'b0;
      step();
      e = exp_q.pop_front();
      o = {BTNP, BTNU, BTND, BTNR, BTNL, switchp};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL bounce c%0d: got %b expected %b", c, o, e);
      end
      if (BTNR === 1'b1) begin
        cnt++;
        if (first == 0) first = c;
      end
    end
    n_cmp++;
    if (first != 11 + DEB + 2) begin
      n_bad++;
      $display("FAIL bounce_latency: got step %0d expected %0d", first, 11 + DEB + 2);
    end
    n_cmp++;
    if (cnt != 1) begin
      n_bad++;
      $display("FAIL bounce_count: got %0d expected 1", cnt);
    end
  endtask

  task automatic test_short_and_switch();
    logic [5:0] e, o;
    int l_cnt    = 0;
    int sw_first = 0;
    for (int c = 1; c <= 25; c++) begin
      raw[4] = (c <= 3);
      raw[5] = (c <= 10);
      step();
      e = exp_q.pop_front();
      o = {BTNP, BTNU, BTND, BTNR, BTNL, switchp};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL short_switch c%0d: got %b expected %b", c, o, e);
      end
      if (BTNL === 1'b1) l_cnt++;
      if (switchp === 1'b1 && sw_first == 0) sw_first = c;
    end
    n_cmp++;
    if (l_cnt != 0) begin
      n_bad++;
      $display("FAIL short_press_ignored: got %0d pulses expected 0", l_cnt);
    end
    n_cmp++;
    if (sw_first != DEB + 3) begin
      n_bad++;
      $display("FAIL switch_latency: got step %0d expected %0d", sw_first, DEB + 3);
    end
  endtask

  task automatic test_exclusion();
    logic [5:0] e, o;
    int p_cnt  = 0;
    int ud_cnt = 0;
    int rl_cnt = 0;
    int u_late = 0;
    for (int c = 1; c <= 55; c++) begin
      raw[0] = (c <= 12);
      raw[2] = (c <= 12);
      raw[3] = (c <= 12);
      raw[4] = (c <= 12);
      raw[1] = (c <= 12) || (c >= 26 && c <= 40);
      step();
      e = exp_q.pop_front();
      o = {BTNP, BTNU, BTND, BTNR, BTNL, switchp};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL exclusion c%0d: got %b expected %b", c, o, e);
      end
      if (c < 26) begin
        if (BTNP === 1'b1) p_cnt++;
        if (BTNU === 1'b1 || BTND === 1'b1) ud_cnt++;
        if (BTNR === 1'b1 || BTNL === 1'b1) rl_cnt++;
      end else if (BTNU === 1'b1) begin
        u_late++;
      end
    end
    n_cmp++;
    if (ud_cnt != 0 || rl_cnt != 0) begin
      n_bad++;
      $display("FAIL pair_suppressed: got ud=%0d rl=%0d expected 0 0", ud_cnt, rl_cnt);
    end
    n_cmp++;
    if (p_cnt != 1) begin
      n_bad++;
      $display("FAIL p_independent: got %0d expected 1", p_cnt);
    end
    n_cmp++;
    if (u_late != 1) begin
      n_bad++;
      $display("FAIL later_press: got %0d expected 1", u_late);
    end
  endtask

  task automatic test_autorepeat();
    logic [5:0] e, o;
    int got[$];
    int want[$];
    want.push_back(DEB + 3);
    if (AR) begin
      for (int t = DEB + 3 + RD; t <= 60; t += RP) want.push_back(t);
    end
    for (int c = 1; c <= 80; c++) begin
      raw[2] = (c <= 60);
      step();
      e = exp_q.pop_front();
      o = {BTNP, BTNU, BTND, BTNR, BTNL, switchp};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL autorepeat c%0d: got %b expected %b", c, o, e);
      end
      if (BTND === 1'b1) got.push_back(c);
    end
    n_cmp++;
    if (got.size() != want.size()) begin
      n_bad++;
      $display("FAIL autorepeat_count: got %0d expected %0d", got.size(), want.size());
    end
    for (int i = 0; i < got.size() && i < want.size(); i++) begin
      n_cmp++;
      if (got[i] != want[i]) begin
        n_bad++;
        $display("FAIL autorepeat_time%0d: got step %0d expected %0d", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    logic [5:0] e, o;
    int first = 0;
    int cnt   = 0;
    // Bring switchp high so the reset has something visible to clear.
    for (int c = 1; c <= 14; c++) begin
      raw[5] = 1'b1;
      raw[0] = (c >= 11);
      step();
      e = exp_q.pop_front();
      o = {BTNP, BTNU, BTND, BTNR, BTNL, switchp};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL mid_press_pre c%0d: got %b expected %b", c, o, e);
      end
    end
    // BTNP sampled at steps 11..14: its debounce counter now holds 2.
    reset = 1'b1;
    #1;
    o = {BTNP, BTNU, BTND, BTNR, BTNL, switchp};
    n_cmp++;
    if (o !== 6'b0) begin
      n_bad++;
      $display("FAIL mid_press_reset: got %b expected 000000", o);
    end
    #9;
    reset = 1'b0;
    model_reset();
    for (int c = 1; c <= 30; c++) begin
      raw[0] = (c <= 15);
      raw[5] = (c <= 15);
      step();
      e = exp_q.pop_front();
      o = {BTNP, BTNU, BTND, BTNR, BTNL, switchp};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL mid_press_post c%0d: got %b expected %b", c, o, e);
      end
      if (BTNP === 1'b1) begin
        cnt++;
        if (first == 0) first = c;
      end
    end
    n_cmp++;
    if (first != DEB + 3 || cnt != 1) begin
      n_bad++;
      $display("FAIL mid_press_repress: got step %0d count %0d expected step %0d count 1",
               first, cnt, DEB + 3);
    end
  endtask

  task automatic test_random();
    logic [5:0] e, o;
    bit fast = 1'b0;
    for (int c = 1; c <= 900; c++) begin
      if (c % 50 == 1) fast = ($urandom_range(0, 3) == 0);
      for (int ch = 0; ch < 6; ch++) begin
        if (fast ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 13) == 0))
          raw[ch] = ~raw[ch];
      end
      // Occasionally move a whole pair together to exercise exclusion.
      if ($urandom_range(0, 29) == 0) raw[2] = raw[1];
      if ($urandom_range(0, 29) == 0) raw[4] = raw[3];
      step();
      e = exp_q.pop_front();
      o = {BTNP, BTNU, BTND, BTNR, BTNL, switchp};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL random c%0d: got %b expected %b", c, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_short_and_switch();
    test_exclusion();
    test_autorepeat();
    test_reset_mid_press();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
